// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - packs symbolic instruction beats into 8-bit codes and writes them to instruction memory
module prog_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [5:0]        in_off,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              cpu_run,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  localparam logic [1:0] KIND_RR  = 2'd0;
  localparam logic [1:0] KIND_IMM = 2'd1;
  localparam logic [1:0] KIND_END = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  // Bit 7 selects jump, bit 6 selects the immediate ALU operand.
  function automatic logic [7:0] encode(input logic [1:0] kind, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] off);
    logic [7:0] code;
    case (kind)
      KIND_RR:  code = {2'b00, rd, rs};
      KIND_IMM: code = {2'b01, rd, rs};
      default:  code = {2'b10, off};
    endcase
    return code;
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    in_ready = (state_q == S_LOAD);
    cpu_run  = (state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (in_kind != KIND_END) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = encode(in_kind, in_rd, in_rs, in_off);
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
              state_d = S_FLUSH;
            end
          end else if (count_q != '0) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader with a cycle-level reference model
module tb_prog_loader;
  localparam int AW = 2;

  logic          clk, rst_n, start, in_valid, in_ready;
  logic [1:0]    in_kind;
  logic [2:0]    in_rd, in_rs;
  logic [5:0]    in_off;
  logic          imem_we, cpu_run, err;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int w_cyc[$];
  int w_addr[$];
  int w_data[$];

  // Reference model: a load accepts beats, full memory waits one cycle, then the program is resident.
  bit m_acc = 0, m_flush = 0, m_res = 0, m_err = 0, m_we = 0;
  int m_count = 0, m_addr = 0, m_data = 0;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs(in_rs), .in_off(in_off),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .cpu_run(cpu_run), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_flush = 0; m_res = 0; m_err = 0; m_we = 0;
      m_count = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_acc && in_valid) begin
        if (in_kind != 2'd3) begin
          m_we   = 1;
          m_addr = m_count % (1 << AW);
          case (in_kind)
            2'd0:    m_data = in_rd * 8 + in_rs;
            2'd1:    m_data = 64 + in_rd * 8 + in_rs;
            default: m_data = 128 + in_off;
          endcase
          m_count++;
          if (m_count == (1 << AW)) begin
            m_acc = 0; m_flush = 1;
          end
        end else if (m_count > 0) begin
          m_acc = 0; m_res = 1;
        end else begin
          m_acc = 0; m_err = 1;
        end
      end else if (m_flush) begin
        m_flush = 0; m_res = 1;
      end else if (!m_acc && start) begin
        m_count = 0; m_err = 0; m_acc = 1; m_res = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_acc);
    chk("cpu_run", cpu_run, m_res);
    chk("count", count, m_count);
    chk("err", err, m_err);
    chk("imem_we", imem_we, m_we);
    if (m_we) begin
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_data);
    end
    if (imem_we === 1'b1) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(imem_addr);
      w_data.push_back(imem_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic beat(input logic [1:0] k, input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] off);
    int n = 0;
    in_valid = 1; in_kind = k; in_rd = rd; in_rs = rs; in_off = off;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got in_ready=%b expected 1", in_ready);
    end
    tick(1);
    in_valid = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 0; start = 0; in_valid = 0; in_kind = 0; in_rd = 0; in_rs = 0; in_off = 0;
    tick(2);
    chk_reset_outputs("rst");
    rst_n = 1;
    tick(2);
    chk("idle_no_ready", in_ready, 0);

    // Basic program with all three encodings.
    n0 = w_addr.size();
    pulse_start();
    beat(2'd0, 3'd3, 3'd5, 6'd0);
    beat(2'd1, 3'd2, 3'd7, 6'd0);
    beat(2'd2, 3'd0, 3'd0, 6'h2A);
    chk("t1_run_before_end", cpu_run, 0);
    beat(2'd3, 3'd0, 3'd0, 6'd0);
    chk("t1_run_after_end", cpu_run, 1);
    chk("t1_count", count, 3);
    chk("t1_nwrites", w_addr.size() - n0, 3);
    chk("t1_a0", w_addr[n0], 0);
    chk("t1_d0", w_data[n0], 8'h1D);
    chk("t1_a1", w_addr[n0+1], 1);
    chk("t1_d1", w_data[n0+1], 8'h57);
    chk("t1_a2", w_addr[n0+2], 2);
    chk("t1_d2", w_data[n0+2], 8'hAA);
    chk("t1_consec01", w_cyc[n0+1] - w_cyc[n0], 1);
    chk("t1_consec12", w_cyc[n0+2] - w_cyc[n0+1], 1);
    tick(2);

    // Empty program sets err and drops back to idle.
    n0 = w_addr.size();
    pulse_start();
    beat(2'd3, 3'd0, 3'd0, 6'd0);
    chk("t2_err", err, 1);
    chk("t2_run", cpu_run, 0);
    chk("t2_ready", in_ready, 0);
    tick(2);
    chk("t2_nwrites", w_addr.size() - n0, 0);
    chk("t2_err_sticky", err, 1);
    pulse_start();
    chk("t2_err_cleared", err, 0);
    chk("t2_ready_load", in_ready, 1);

    // Memory-full load with no end beat.
    n0 = w_addr.size();
    for (int i = 0; i < 4; i++) beat(2'd0, 3'(i), 3'(i), 6'd0);
    chk("t3_flush_ready", in_ready, 0);
    chk("t3_flush_run", cpu_run, 0);
    chk("t3_flush_we", imem_we, 1);
    chk("t3_count", count, 4);
    tick(1);
    chk("t3_run", cpu_run, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_count_sat", count, 4);
    chk("t3_nwrites", w_addr.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", w_addr[n0+i], i);
      chk("t3_data", w_data[n0+i], i * 9);
    end
    tick(2);

    // Gap in in_valid.
    pulse_start();
    n0 = w_addr.size();
    beat(2'd0, 3'd1, 3'd2, 6'd0);
    tick(1);
    beat(2'd1, 3'd4, 3'd3, 6'd0);
    beat(2'd3, 3'd0, 3'd0, 6'd0);
    chk("t4_nwrites", w_addr.size() - n0, 2);
    chk("t4_a0", w_addr[n0], 0);
    chk("t4_a1", w_addr[n0+1], 1);
    chk("t4_d1", w_data[n0+1], 8'h63);
    chk("t4_gap", w_cyc[n0+1] - w_cyc[n0], 2);
    tick(2);

    // Reload from DONE.
    n0 = w_addr.size();
    chk("t5_run_pre", cpu_run, 1);
    pulse_start();
    chk("t5_run_dropped", cpu_run, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_count_zero", count, 0);
    beat(2'd2, 3'd0, 3'd0, 6'd1);
    chk("t5_run_mid", cpu_run, 0);
    beat(2'd3, 3'd0, 3'd0, 6'd0);
    chk("t5_run_post", cpu_run, 1);
    chk("t5_count", count, 1);
    chk("t5_nwrites", w_addr.size() - n0, 1);
    chk("t5_a0", w_addr[n0], 0);
    chk("t5_d0", w_data[n0], 8'h81);
    tick(2);

    // Asynchronous reset mid-load.
    pulse_start();
    beat(2'd0, 3'd5, 3'd6, 6'd0);
    beat(2'd1, 3'd7, 3'd1, 6'd0);
    chk("t6_count_pre", count, 2);
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs("t6");
    tick(2);
    rst_n = 1;
    tick(3);
    chk("t6_idle_ready", in_ready, 0);
    chk("t6_idle_run", cpu_run, 0);
    pulse_start();
    chk("t6_resume_ready", in_ready, 1);
    beat(2'd0, 3'd1, 3'd1, 6'd0);
    beat(2'd3, 3'd0, 3'd0, 6'd0);
    chk("t6_resume_run", cpu_run, 1);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that is the write side of the instruction path: it accepts symbolic instruction fields over a valid/ready stream, packs them into the 8-bit instruction code consumed by the control unit, and writes them sequentially into instruction memory. When the program is complete it releases the pipeline via `cpu_run`. It sits between the test/boot host and the instruction-memory write port, ahead of the pipelined core.

## Interface
- `ADDR_W`, default 5, is the instruction-memory address width. Depth is 2^ADDR_W words.
- `clk`, input, 1 bit: single clock. All state changes on its rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `start`, input, 1 bit: begin a new load. Acted on in IDLE or DONE only.
- `in_valid`, input, 1 bit: an instruction beat is present.
- `in_ready`, output, 1 bit: the loader accepts the beat this cycle.
- `in_kind`, input, 2 bits: beat type. 0 is ALU reg-reg, 1 is ALU immediate, 2 is jump, 3 is end of program.
- `in_rd`, input, 3 bits: destination register.
- `in_rs`, input, 3 bits: source register, or imm3 when kind is 1.
- `in_off`, input, 6 bits: jump offset when kind is 2.
- `imem_we`, output, 1 bit: instruction-memory write strobe.
- `imem_addr`, output, ADDR_W bits: write address.
- `imem_wdata`, output, 8 bits: encoded instruction code.
- `count`, output, ADDR_W+1 bits: number of words accepted in the current load.
- `cpu_run`, output, 1 bit: high while a complete program is resident.
- `err`, output, 1 bit: sticky flag, set on an empty program.

## Operation
- Encoding:
  - kind 0 encodes as {2'b00, rd, rs}.
  - kind 1 encodes as {2'b01, rd, imm3}.
  - kind 2 encodes as {2'b10, off}.
  - Bit 7 is the jump bit (PCSrc / ImmSel); bit 6 is the immediate-ALU bit (ALUSrc).
  - kind 3 writes nothing.
- States: IDLE, LOAD, FLUSH, DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=0, `cpu_run`=0.
  - `start` clears `count`, the write address and `err`, then goes to LOAD.
- LOAD:
  - `in_ready`=1.
  - Handshake is `in_valid & in_ready` at a rising edge.
  - Beat kind 0–2: registers the encoded word at the current address, raises `imem_we`, increments the address and `count`.
  - If that beat fills the last address (`count` becomes 2^ADDR_W), go to FLUSH.
  - Beat kind 3 with `count`>0: go to DONE.
  - Beat kind 3 with `count`==0: set `err`, go to IDLE.
- FLUSH:
  - `in_ready`=0. Lasts one cycle, during which the final write is presented.
  - Then go to DONE. A memory-full load needs no end beat.
- DONE:
  - `cpu_run`=1, `in_ready`=0.
  - `start` drops `cpu_run` at that edge and enters LOAD with `count`=0.
- `start` in LOAD or FLUSH is ignored.
- `in_kind`/field values while `in_valid`=0 are don't-care.
- The write address wraps arithmetically modulo 2^ADDR_W. It is reset to 0 on `start`, so no overwrite occurs within a load.
- `count` saturates at 2^ADDR_W. It is never incremented beyond that, since `in_ready` is low in FLUSH.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `cpu_run`=0, `err`=0.
- Reset mid-load abandons the load and returns to IDLE immediately. Memory contents are left as written.
- Latency: a beat accepted at edge N presents `imem_we`=1 with addr/data during cycle N+1. The write commits at edge N+1.
- `imem_we` is high exactly one cycle per accepted kind 0–2 beat.
- Back-to-back beats give back-to-back single-cycle writes, so throughput is one beat per cycle.
- End beat accepted at edge N: the state is DONE and `cpu_run`=1 from cycle N+1. Any write from the beat at N−1 has already committed at edge N.
- Last-address beat at edge N: FLUSH during cycle N+1, DONE and `cpu_run`=1 from cycle N+2.
- `count` updates at the handshake edge. `err` updates at the end-beat edge.
- `start` in DONE at edge N: `cpu_run`=0 and `in_ready`=1 from cycle N+1.

## Test plan
- Reset, then `start`, then beats kind0(rd=3,rs=5), kind1(rd=2,imm=7), kind2(off=0x2A), kind3. Required: writes 0x1D@0, 0x57@1, 0xAA@2 on consecutive cycles; `count`=3; `cpu_run` rises the cycle after the end beat.
- `start`, then kind3 immediately. Required: no `imem_we`, `err`=1, state IDLE, `cpu_run`=0. A following `start` clears `err`.
- With ADDR_W=2, `start` and 4 kind0 beats and no end beat. Required: addresses 0..3 written, `in_ready` low after the 4th handshake, FLUSH for 1 cycle, then `cpu_run`=1 and `count`=4.
- `in_valid` toggling 1,0,1 during LOAD. Required: exactly 2 writes, no write during the gap, addresses 0 and 1.
- Reload: in DONE, pulse `start`, load 1 beat kind2(off=1) and kind3. Required: `cpu_run` is low between the `start` edge and the end beat; 0x81 written @0; `count`=1.
- Assert `rst_n`=0 mid-LOAD after 2 beats. Required: all outputs return to reset values asynchronously; `start` is needed to resume.
